// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/forwarding bundle between decode and the register scoreboard.
// The master side is the decode stage; the slave side is the scoreboard itself.
interface reg_scoreboard_if #(
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic              issue_ready;
  logic [4:0]        issue_rs1;
  logic [4:0]        issue_rs2;
  logic              issue_use1;
  logic              issue_use2;
  logic [4:0]        issue_rd;
  logic              issue_wreg;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              fwd1_en;
  logic              fwd2_en;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic              sb_err;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
           issue_rd, issue_wreg, wb_valid, wb_rd, wb_data, flush,
    input  issue_ready, fwd1_en, fwd2_en, fwd1_data, fwd2_data, sb_err
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use1, issue_use2,
           issue_rd, issue_wreg, wb_valid, wb_rd, wb_data, flush,
    output issue_ready, fwd1_en, fwd2_en, fwd1_data, fwd2_data, sb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: 2-bit pending-write counters for x1..x31, RAW/WAW-limit stall,
// and a one-cycle writeback forward to cover the registered register-file read.
module reg_scoreboard (
  input  logic             Clock,
  input  logic             nReset,
  reg_scoreboard_if.slave  bus
);
  localparam int DATA_W = 32;

  logic [1:0]        cnt_q [1:31];
  logic [1:0]        cnt_d [1:31];
  logic              fwd1_en_q, fwd1_en_d;
  logic              fwd2_en_q, fwd2_en_d;
  logic [DATA_W-1:0] fwd1_data_q, fwd1_data_d;
  logic [DATA_W-1:0] fwd2_data_q, fwd2_data_d;
  logic              sb_err_q, sb_err_d;

  logic [1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic       fwd1_ok, fwd2_ok, haz1, haz2, rd_full;
  logic       issue_ready, accept, inc, dec;

  // x0 has no counter, so every lookup defaults to zero.
  always_comb begin
    cnt_rs1 = 2'd0;
    cnt_rs2 = 2'd0;
    cnt_rd  = 2'd0;
    cnt_wb  = 2'd0;
    for (int i = 1; i < 32; i++) begin
      if (bus.issue_rs1 == 5'(i)) cnt_rs1 = cnt_q[i];
      if (bus.issue_rs2 == 5'(i)) cnt_rs2 = cnt_q[i];
      if (bus.issue_rd  == 5'(i)) cnt_rd  = cnt_q[i];
      if (bus.wb_rd     == 5'(i)) cnt_wb  = cnt_q[i];
    end
  end

  // The last outstanding write landing this cycle is forwarded instead of stalling.
  assign fwd1_ok = bus.wb_valid && (bus.wb_rd == bus.issue_rs1) && (cnt_rs1 == 2'd1);
  assign fwd2_ok = bus.wb_valid && (bus.wb_rd == bus.issue_rs2) && (cnt_rs2 == 2'd1);
  assign haz1    = bus.issue_use1 && (bus.issue_rs1 != 5'd0) && (cnt_rs1 != 2'd0) && !fwd1_ok;
  assign haz2    = bus.issue_use2 && (bus.issue_rs2 != 5'd0) && (cnt_rs2 != 2'd0) && !fwd2_ok;
  assign rd_full = bus.issue_wreg && (bus.issue_rd != 5'd0) && (cnt_rd == 2'd3);

  assign issue_ready = !bus.flush && !haz1 && !haz2 && !rd_full;
  assign accept      = bus.issue_valid && issue_ready;
  assign inc         = accept && bus.issue_wreg && (bus.issue_rd != 5'd0);
  assign dec         = !bus.flush && bus.wb_valid && (bus.wb_rd != 5'd0);

  always_comb begin
    sb_err_d    = sb_err_q | (dec && (cnt_wb == 2'd0));
    fwd1_en_d   = accept && bus.issue_use1 && fwd1_ok;
    fwd2_en_d   = accept && bus.issue_use2 && fwd2_ok;
    fwd1_data_d = fwd1_en_d ? bus.wb_data : fwd1_data_q;
    fwd2_data_d = fwd2_en_d ? bus.wb_data : fwd2_data_q;
    for (int i = 1; i < 32; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.flush) begin
        cnt_d[i] = 2'd0;
      end else if (inc && (bus.issue_rd == 5'(i)) && !(dec && (bus.wb_rd == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec && (bus.wb_rd == 5'(i)) && !(inc && (bus.issue_rd == 5'(i)))
                   && (cnt_q[i] != 2'd0)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= 2'd0;
      fwd1_en_q   <= 1'b0;
      fwd2_en_q   <= 1'b0;
      fwd1_data_q <= '0;
      fwd2_data_q <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      for (int i = 1; i < 32; i++) cnt_q[i] <= cnt_d[i];
      fwd1_en_q   <= fwd1_en_d;
      fwd2_en_q   <= fwd2_en_d;
      fwd1_data_q <= fwd1_data_d;
      fwd2_data_q <= fwd2_data_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.fwd1_en     = fwd1_en_q;
  assign bus.fwd2_en     = fwd2_en_q;
  assign bus.fwd1_data   = fwd1_data_q;
  assign bus.fwd2_data   = fwd2_data_q;
  assign bus.sb_err      = sb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, reset-in-stall sequence,
// then randomized traffic compared against a per-register pending-count model.
module tb_reg_scoreboard;
  logic Clock = 1'b0;
  logic nReset = 1'b0;
  always #5 Clock = ~Clock;

  reg_scoreboard_if #(.DATA_W(32)) bus ();

  reg_scoreboard dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  typedef struct {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic w; logic wbv; logic [4:0] wbrd; logic [31:0] wbd; logic fl;
    logic e_rdy; logic e_f1; logic [31:0] e_f1d; logic e_f2; logic [31:0] e_f2d; logic e_err;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: outstanding writes per architectural register.
  int          mcnt [32];
  logic        m_err, m_f1, m_f2;
  logic [31:0] m_f1d, m_f2d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    m_err = 0; m_f1 = 0; m_f2 = 0; m_f1d = '0; m_f2d = '0;
  endtask

  function automatic logic src_blocked(input logic use_it, input logic [4:0] rs);
    if (!use_it || rs == 0 || mcnt[rs] == 0) return 1'b0;
    if (bus.wb_valid && bus.wb_rd == rs && mcnt[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic model_ready();
    if (bus.flush) return 1'b0;
    if (src_blocked(bus.issue_use1, bus.issue_rs1)) return 1'b0;
    if (src_blocked(bus.issue_use2, bus.issue_rs2)) return 1'b0;
    if (bus.issue_wreg && bus.issue_rd != 0 && mcnt[bus.issue_rd] == 3) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic acc, f1, f2;
    int inc_r, dec_r;
    acc = bus.issue_valid && model_ready();
    f1 = acc && bus.issue_use1 && bus.issue_rs1 != 0 && bus.wb_valid &&
         bus.wb_rd == bus.issue_rs1 && mcnt[bus.issue_rs1] == 1;
    f2 = acc && bus.issue_use2 && bus.issue_rs2 != 0 && bus.wb_valid &&
         bus.wb_rd == bus.issue_rs2 && mcnt[bus.issue_rs2] == 1;
    if (f1) m_f1d = bus.wb_data;
    if (f2) m_f2d = bus.wb_data;
    m_f1 = f1; m_f2 = f2;
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      inc_r = (acc && bus.issue_wreg && bus.issue_rd != 0) ? int'(bus.issue_rd) : -1;
      dec_r = (bus.wb_valid && bus.wb_rd != 0) ? int'(bus.wb_rd) : -1;
      if (dec_r > 0 && mcnt[dec_r] == 0) m_err = 1;
      if (inc_r != dec_r) begin
        if (inc_r > 0) mcnt[inc_r] = mcnt[inc_r] + 1;
        if (dec_r > 0 && mcnt[dec_r] > 0) mcnt[dec_r] = mcnt[dec_r] - 1;
      end
    end
  endtask

  task automatic drive(input vec_t t);
    bus.issue_valid = t.v;  bus.issue_rs1 = t.rs1; bus.issue_use1 = t.u1;
    bus.issue_rs2 = t.rs2;  bus.issue_use2 = t.u2; bus.issue_rd = t.rd;
    bus.issue_wreg = t.w;   bus.wb_valid = t.wbv;  bus.wb_rd = t.wbrd;
    bus.wb_data = t.wbd;    bus.flush = t.fl;
  endtask

  // Inputs are already stable; ready sampled at negedge, registered outputs #1 after posedge.
  task automatic run_cycle(input string tag, input logic e_rdy, input logic e_f1,
                           input logic [31:0] e_f1d, input logic e_f2,
                           input logic [31:0] e_f2d, input logic e_err);
    @(negedge Clock);
    chk({tag, " ready"}, 32'(bus.issue_ready), 32'(e_rdy));
    model_step();
    @(posedge Clock);
    #1;
    chk({tag, " fwd1_en"},   32'(bus.fwd1_en), 32'(e_f1));
    chk({tag, " fwd1_data"}, bus.fwd1_data,    e_f1d);
    chk({tag, " fwd2_en"},   32'(bus.fwd2_en), 32'(e_f2));
    chk({tag, " fwd2_data"}, bus.fwd2_data,    e_f2d);
    chk({tag, " sb_err"},    32'(bus.sb_err),  32'(e_err));
  endtask

  task automatic run_model_cycle(input string tag);
    logic r;
    @(negedge Clock);
    r = model_ready();
    chk({tag, " ready"}, 32'(bus.issue_ready), 32'(r));
    model_step();
    @(posedge Clock);
    #1;
    chk({tag, " fwd1_en"},   32'(bus.fwd1_en), 32'(m_f1));
    chk({tag, " fwd1_data"}, bus.fwd1_data,    m_f1d);
    chk({tag, " fwd2_en"},   32'(bus.fwd2_en), 32'(m_f2));
    chk({tag, " fwd2_data"}, bus.fwd2_data,    m_f2d);
    chk({tag, " sb_err"},    32'(bus.sb_err),  32'(m_err));
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
      input logic [4:0] rs2, input logic u2, input logic [4:0] rd, input logic w,
      input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbd, input logic fl,
      input logic e_rdy, input logic e_f1, input logic [31:0] e_f1d, input logic e_f2,
      input logic [31:0] e_f2d, input logic e_err);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.w = w;
    t.wbv = wbv; t.wbrd = wbrd; t.wbd = wbd; t.fl = fl;
    t.e_rdy = e_rdy; t.e_f1 = e_f1; t.e_f1d = e_f1d; t.e_f2 = e_f2; t.e_f2d = e_f2d;
    t.e_err = e_err;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [21];
    vec_t idle;
    vec_t rv;
    logic [31:0] DB, C5;
    DB = 32'hDEADBEEF;
    C5 = 32'h12345678;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);

    //            v rs1 u1 rs2 u2 rd w wbv wbrd wbd fl | rdy f1 f1d f2 f2d err
    tbl[0]  = mk(1, 0,0, 0,0, 5,1, 0,0,0,     0,  1,0,0, 0,0, 0);
    tbl[1]  = mk(1, 5,1, 0,0, 0,0, 0,0,0,     0,  0,0,0, 0,0, 0);
    tbl[2]  = mk(1, 5,1, 0,0, 0,0, 0,0,0,     0,  0,0,0, 0,0, 0);
    tbl[3]  = mk(1, 5,1, 0,0, 0,0, 1,5,DB,    0,  1,1,DB,0,0, 0);
    tbl[4]  = mk(0, 0,0, 0,0, 0,0, 0,0,0,     0,  1,0,DB,0,0, 0);
    tbl[5]  = mk(1, 0,0, 0,0, 6,1, 0,0,0,     0,  1,0,DB,0,0, 0);
    tbl[6]  = mk(1, 0,0, 6,1, 0,0, 1,6,C5,    0,  1,0,DB,1,C5,0);
    tbl[7]  = mk(1, 0,0, 0,0, 7,1, 0,0,0,     0,  1,0,DB,0,C5,0);
    tbl[8]  = mk(1, 0,0, 0,0, 7,1, 0,0,0,     0,  1,0,DB,0,C5,0);
    tbl[9]  = mk(1, 0,0, 0,0, 7,1, 0,0,0,     0,  1,0,DB,0,C5,0);
    tbl[10] = mk(1, 0,0, 0,0, 7,1, 0,0,0,     0,  0,0,DB,0,C5,0);
    tbl[11] = mk(0, 0,0, 0,0, 0,0, 1,7,0,     0,  1,0,DB,0,C5,0);
    tbl[12] = mk(1, 0,0, 0,0, 7,1, 0,0,0,     0,  1,0,DB,0,C5,0);
    tbl[13] = mk(1, 0,0, 0,0, 3,1, 0,0,0,     0,  1,0,DB,0,C5,0);
    tbl[14] = mk(1, 0,0, 0,0, 3,1, 1,3,32'h11,0,  1,0,DB,0,C5,0);
    tbl[15] = mk(1, 3,1, 0,0, 0,0, 0,0,0,     0,  0,0,DB,0,C5,0);
    tbl[16] = mk(1, 0,1, 0,1, 0,1, 1,0,32'h22,0,  1,0,DB,0,C5,0);
    tbl[17] = mk(1, 0,0, 0,0, 5,1, 1,3,0,     1,  0,0,DB,0,C5,0);
    tbl[18] = mk(1, 5,1, 7,1, 3,0, 0,0,0,     0,  1,0,DB,0,C5,0);
    tbl[19] = mk(0, 0,0, 0,0, 0,0, 1,9,0,     0,  1,0,DB,0,C5,1);
    tbl[20] = mk(0, 0,0, 0,0, 0,0, 0,0,0,     0,  1,0,DB,0,C5,1);

    drive(idle);
    model_reset();
    repeat (3) @(posedge Clock);
    #1;
    chk("reset fwd1_en", 32'(bus.fwd1_en), 32'd0);
    chk("reset fwd1_data", bus.fwd1_data, 32'd0);
    chk("reset sb_err", 32'(bus.sb_err), 32'd0);
    nReset = 1'b1;
    @(posedge Clock);
    #1;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      run_cycle($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_f1, tbl[i].e_f1d,
                tbl[i].e_f2, tbl[i].e_f2d, tbl[i].e_err);
    end

    // Reset asserted while an instruction is stalled on x4.
    drive(mk(1,0,0,0,0,4,1,0,0,0,0, 0,0,0,0,0,0));
    run_model_cycle("stall_setup");
    drive(mk(1,4,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge Clock);
    chk("stall ready", 32'(bus.issue_ready), 32'd0);
    #2;
    nReset = 1'b0;
    model_reset();
    #1;
    chk("async fwd1_data", bus.fwd1_data, 32'd0);
    chk("async fwd2_data", bus.fwd2_data, 32'd0);
    chk("async fwd1_en", 32'(bus.fwd1_en), 32'd0);
    chk("async sb_err", 32'(bus.sb_err), 32'd0);
    chk("async ready", 32'(bus.issue_ready), 32'd1);
    @(posedge Clock);
    #1;
    nReset = 1'b1;
    run_model_cycle("post_reset");

    // Randomized traffic over x0..x7 to keep hazards frequent.
    for (int n = 0; n < 600; n++) begin
      rv = idle;
      rv.v = ($urandom_range(0, 3) != 0);
      rv.rs1 = 5'($urandom_range(0, 7)); rv.u1 = 1'($urandom_range(0, 1));
      rv.rs2 = 5'($urandom_range(0, 7)); rv.u2 = 1'($urandom_range(0, 1));
      rv.rd = 5'($urandom_range(0, 7));  rv.w = 1'($urandom_range(0, 1));
      rv.wbd = $urandom();
      rv.fl = ($urandom_range(0, 31) == 0);
      rv.wbv = 1'($urandom_range(0, 1));
      if (rv.wbv) begin
        int start;
        logic found;
        start = $urandom_range(1, 7);
        found = 1'b0;
        for (int k = 0; k < 7; k++) begin
          int r;
          r = 1 + ((start - 1 + k) % 7);
          if (!found && mcnt[r] > 0) begin rv.wbrd = 5'(r); found = 1'b1; end
        end
        if ($urandom_range(0, 15) == 0) rv.wbrd = 5'($urandom_range(0, 7));
        else if (!found) rv.wbv = 1'b0;
      end
      drive(rv);
      run_model_cycle($sformatf("rnd%0d", n));
    end

    drive(idle);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have port Clock, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port nReset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port issue_valid, input, 1, decode presents an instruction this cycle.
REQ-004 SHALL have port issue_ready, output, 1, combinational accept; issue accepted when issue_valid && issue_ready.
REQ-005 SHALL have ports issue_rs1 and issue_rs2, input, 5 each, source register addresses (same values driven to register file read addresses).
REQ-006 SHALL have ports issue_use1 and issue_use2, input, 1 each, instruction actually reads rs1 or rs2.
REQ-007 SHALL have ports issue_rd, input, 5, and issue_wreg, input, 1, destination register and write enable of the issuing instruction.
REQ-008 SHALL have ports wb_valid, input, 1; wb_rd, input, 5; wb_data, input, 32; this is the writeback presented to the register file this cycle.
REQ-009 SHALL have port flush, input, 1, squash all in-flight instructions.
REQ-010 SHALL have ports fwd1_en and fwd2_en, output, 1 each, registered; select forwarded data instead of register file rs1 or rs2 output.
REQ-011 SHALL have ports fwd1_data and fwd2_data, output, 32 each, registered forwarded values.
REQ-012 SHALL have port sb_err, output, 1, sticky writeback-without-pending error flag.

Function
REQ-013 SHALL hold one 2-bit pending counter per register x1..x31; x0 is never tracked and always reads as count 0.
REQ-014 SHALL treat a source as hazarded when it is used, nonzero, its count is nonzero, and the forwarding exception in REQ-016 does not apply.
REQ-015 SHALL drive issue_ready = !flush && no hazarded source && !(issue_wreg && issue_rd!=0 && count[issue_rd]==3).
REQ-016 SHALL apply the forwarding exception when wb_valid && wb_rd==source && count[source]==1: no stall; next cycle fwdN_en=1 and fwdN_data=wb_data captured this cycle. This is needed because the register file read is registered and returns the pre-write value.
REQ-017 SHALL, on an accepted issue with issue_wreg && issue_rd!=0, increment count[issue_rd] at the next edge.
REQ-018 SHALL, on wb_valid && wb_rd!=0, decrement count[wb_rd] at the next edge.
REQ-019 SHALL leave the count unchanged when an increment and a decrement target the same register in the same cycle.
REQ-020 SHALL set sb_err and leave the count at 0 when a decrement targets a register with count 0; sb_err clears only on reset.
REQ-021 SHALL clear fwdN_en at the next edge for any cycle without an accepted issue meeting REQ-016 for that source; fwdN_data holds its last value.
REQ-022 SHALL, when flush=1, clear all counts and both fwdN_en at the next edge, ignore issue and writeback in that cycle, and hold issue_ready=0.
REQ-023 SHALL make issue_ready independent of issue_valid; counters update only on acceptance.
REQ-024 SHALL allow a WAW issue to a register with count 1 or 2 without stalling.

Reset
REQ-025 SHALL, while nReset=0, force all counts to 0, fwd1_en=fwd2_en=0, fwd1_data=fwd2_data=0, and sb_err=0, independent of Clock.
REQ-026 SHALL, on reset assertion mid-operation, discard all pending state; issue_ready after release SHALL be 1 (absent flush).

Verification
REQ-027 SHALL cover RAW stall: issue x5 wreg, then issue use1 rs1=x5 -> issue_ready=0 until the cycle wb_rd=5 arrives.
REQ-028 SHALL cover forward: count[x5]=1, issue rs1=x5 with wb_valid, wb_rd=5, wb_data=0xDEADBEEF -> ready=1; next cycle fwd1_en=1, fwd1_data=0xDEADBEEF; the following cycle fwd1_en=0.
REQ-029 SHALL cover saturation: three accepted issues to x7 -> fourth issue rd=x7 has ready=0; one wb_rd=7 -> ready=1.
REQ-030 SHALL cover simultaneous events: issue rd=x3 and wb_rd=3 in the same cycle with count 1 -> count stays 1; x0 issue and writeback -> no stall, no count change.
REQ-031 SHALL cover flush: counts nonzero, flush=1 -> ready=0 that cycle; next cycle all counts 0 and an issue of rs1=x5 is accepted.
REQ-032 SHALL cover error and reset: wb_rd=9 with count 0 -> sb_err=1 sticky; nReset low mid-stall -> all outputs 0 immediately and ready=1 after release.
